// File: rtl/mram_spi_pkg.sv
// Shared definitions for the MRAM/SPI read path: widths, the serialiser FSM
// encoding, the default settle time and a bitwise majority helper.
package mram_spi_pkg;

  localparam int MRAM_DATA_W           = 16;
  localparam int PTS_IDX_W             = 4;
  localparam int PTS_SETTLE_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    PTS_IDLE    = 2'd0,
    PTS_SETTLE  = 2'd1,
    PTS_CAPTURE = 2'd2,
    PTS_HOLD    = 2'd3
  } pts_state_e;

  function automatic logic [MRAM_DATA_W-1:0] maj3(
    input logic [MRAM_DATA_W-1:0] a,
    input logic [MRAM_DATA_W-1:0] b,
    input logic [MRAM_DATA_W-1:0] c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/pts_bit_mux.sv
// Index-to-bit selection for the MISO stream: low byte first, MSB first
// within each byte.
module pts_bit_mux
  import mram_spi_pkg::*;
(
  input  logic [MRAM_DATA_W-1:0] word_i,
  input  logic [PTS_IDX_W-1:0]   index_i,
  output logic                   bit_o
);

  // tx_order[k] is the word bit that goes out when the slave presents index k
  logic [MRAM_DATA_W-1:0] tx_order;

  for (genvar gi = 0; gi < MRAM_DATA_W; gi++) begin : g_order
    if (gi < 8) begin : g_lo
      assign tx_order[gi] = word_i[7-gi];
    end else begin : g_hi
      assign tx_order[gi] = word_i[23-gi];
    end
  end

  assign bit_o = tx_order[index_i];

endmodule

// File: rtl/mram_read_pts.sv
// MRAM read parallel-to-serial stage: samples the MRAM bus a settle time after
// each read strobe and streams the held word bit-by-bit toward SPI MISO.
// Build option MRAM_PTS_SAMPLE_VOTE_EN: 3-cycle capture with bitwise majority vote.
module mram_read_pts
  import mram_spi_pkg::*;
#(
  parameter int SETTLE_CYCLES = PTS_SETTLE_CYCLES_DEF,
  parameter int DATA_W        = MRAM_DATA_W
)(
  input  logic                 FPGA_clk,
  input  logic                 FPGA_rst_n,
  input  logic                 pts_en,
  input  logic                 read_en_n,
  input  logic [PTS_IDX_W-1:0] index,
  input  logic [DATA_W-1:0]    mram_dq_in,
  output logic                 ser_data_out,
  output logic [DATA_W-1:0]    word_out,
  output logic                 word_valid,
  output logic [7:0]           capture_cnt
);

  localparam logic [1:0] SETTLE_LOAD = 2'(SETTLE_CYCLES - 1);

  pts_state_e        state_q;
  logic [1:0]        settle_cnt_q;
  logic [DATA_W-1:0] dq_q;
  logic [DATA_W-1:0] word_q;
  logic              rd_n_q;
  logic              valid_q;
  logic              ser_q;
  logic [7:0]        cnt_q;
  logic              rd_fall;
  logic              ser_bit_d;
`ifdef MRAM_PTS_SAMPLE_VOTE_EN
  logic [1:0]        vote_idx_q;
  logic [DATA_W-1:0] samp0_q;
  logic [DATA_W-1:0] samp1_q;
`endif

  assign rd_fall = rd_n_q & ~read_en_n;

  pts_bit_mux u_bit_mux (
    .word_i  (word_q),
    .index_i (index),
    .bit_o   (ser_bit_d)
  );

  always_ff @(posedge FPGA_clk or negedge FPGA_rst_n) begin
    if (!FPGA_rst_n) begin
      state_q      <= PTS_IDLE;
      settle_cnt_q <= '0;
      dq_q         <= '0;
      word_q       <= '0;
      rd_n_q       <= 1'b1;
      valid_q      <= 1'b0;
      ser_q        <= 1'b0;
      cnt_q        <= '0;
`ifdef MRAM_PTS_SAMPLE_VOTE_EN
      vote_idx_q   <= '0;
      samp0_q      <= '0;
      samp1_q      <= '0;
`endif
    end else begin
      // the bus is asynchronous, so nothing downstream ever sees it unregistered
      dq_q   <= mram_dq_in;
      rd_n_q <= read_en_n;
      ser_q  <= pts_en & valid_q & ser_bit_d;

      if (!pts_en) begin
        state_q <= PTS_IDLE;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          PTS_IDLE: begin
            if (rd_fall) begin
              settle_cnt_q <= SETTLE_LOAD;
              state_q      <= PTS_SETTLE;
            end
          end
          PTS_SETTLE: begin
            if (rd_fall) begin
              settle_cnt_q <= SETTLE_LOAD;
            end else if (settle_cnt_q == 2'd0) begin
              state_q <= PTS_CAPTURE;
`ifdef MRAM_PTS_SAMPLE_VOTE_EN
              vote_idx_q <= '0;
`endif
            end else begin
              settle_cnt_q <= settle_cnt_q - 2'd1;
            end
          end
          PTS_CAPTURE: begin
`ifdef MRAM_PTS_SAMPLE_VOTE_EN
            case (vote_idx_q)
              2'd0: begin
                samp0_q    <= dq_q;
                vote_idx_q <= 2'd1;
              end
              2'd1: begin
                samp1_q    <= dq_q;
                vote_idx_q <= 2'd2;
              end
              default: begin
                word_q  <= maj3(samp0_q, samp1_q, dq_q);
                valid_q <= 1'b1;
                cnt_q   <= cnt_q + 8'd1;
                state_q <= PTS_HOLD;
              end
            endcase
`else
            word_q  <= dq_q;
            valid_q <= 1'b1;
            cnt_q   <= cnt_q + 8'd1;
            state_q <= PTS_HOLD;
`endif
          end
          PTS_HOLD: begin
            if (rd_fall) begin
              settle_cnt_q <= SETTLE_LOAD;
              state_q      <= PTS_SETTLE;
            end
          end
          default: state_q <= PTS_IDLE;
        endcase
      end
    end
  end

  assign ser_data_out = ser_q;
  assign word_out     = word_q;
  assign word_valid   = valid_q;
  assign capture_cnt  = cnt_q;

endmodule

// File: doc/mram_read_pts.md
Name: mram_read_pts

Overview:
- Parallel-to-serial stage directly downstream of the MRAM data bus and upstream of the SPI slave MISO path.
- Samples the 16-bit MRAM read word after a programmable settle time, each time the SPI slave pulses the MRAM read strobe while read serialisation is enabled.
- Holds the sampled word and presents one bit at a time on ser_data_out, selected by the slave's 4-bit bit index, so that read data streams back to the SPI master.

Parameters:
- SETTLE_CYCLES, 2, FPGA_clk cycles from read strobe assertion to data sample; legal range 1..3, so the sample lands inside the slave's 4-cycle MRAM read window.
- DATA_W, 16, MRAM word width; fixed at 16 because index is 4 bits.

Ports:
- FPGA_clk  in  1  system clock.
- FPGA_rst_n  in  1  reset.
- pts_en  in  1  serialiser enable from the SPI slave; high for a whole read transaction.
- read_en_n  in  1  MRAM read strobe, active low, from the SPI slave.
- index  in  4  bit index from the SPI slave: 0..7 is byte 0, 8..15 is byte 1.
- mram_dq_in  in  16  MRAM data bus, asynchronous to FPGA_clk.
- ser_data_out  out  1  serial bit to SPI MISO.
- word_out  out  16  last captured word, for debug and LEDs.
- word_valid  out  1  high once a word has been captured in the current pts_en window.
- capture_cnt  out  8  number of captures since reset; wraps 255 -> 0.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset values: ser_data_out=0, word_out=0, word_valid=0, capture_cnt=0, FSM=IDLE, input register=0, read_en_n history=1.
- Input register: mram_dq_in is registered every cycle (dq_r) before any use.
- Strobe edge: rd_fall = (read_en_n_d==1 && read_en_n==0), where read_en_n_d is read_en_n delayed one cycle.
- States:
  - IDLE: if pts_en && rd_fall, load settle counter = SETTLE_CYCLES-1 and go to SETTLE. Otherwise stay.
  - SETTLE: count down. At 0, go to CAPTURE. If rd_fall occurs again, reload the counter (restart). If pts_en drops, go to IDLE with no capture.
  - CAPTURE (1 cycle): word_out <= dq_r, word_valid <= 1, capture_cnt <= capture_cnt+1, then go to HOLD.
  - HOLD: serialise. If rd_fall, reload the counter and go to SETTLE; word_out is held until the new capture. If pts_en drops, go to IDLE.
- Capture latency: the sample is taken SETTLE_CYCLES+1 cycles after the read_en_n low level is first seen. word_out updates on the following edge.
- Bit mapping: low byte first, MSB first within each byte.
  - index 0..7 selects word_out[7-index].
  - index 8..15 selects word_out[23-index].
- ser_data_out is registered. It reflects index and word_out from the previous cycle (1-cycle latency). It is 0 whenever word_valid=0.
- Leaving the pts_en window: when pts_en falls, word_valid <= 0 and ser_data_out <= 0 on the next edge. word_out and capture_cnt are held.
- rd_fall while pts_en=0 is ignored.
- Asynchronous reset mid-SETTLE or mid-CAPTURE aborts with no partial update; all outputs take their reset values immediately.

Optional Feature:
- Macro: MRAM_PTS_SAMPLE_VOTE_EN.
- Defined: CAPTURE lasts 3 cycles and samples dq_r on 3 consecutive cycles. word_out is the bitwise majority of the three samples. The capture latency grows by 2 cycles, so the slave's MRAM_delay must be at least SETTLE_CYCLES+3.
- Undefined: single-sample capture as described above.

Decomposition:
- Shared package mram_spi_pkg holds:
  - MRAM_DATA_W = 16;
  - PTS_IDX_W = 4;
  - the FSM state encoding for IDLE, SETTLE, CAPTURE, HOLD;
  - the default SETTLE_CYCLES.
- One natural sub-module, pts_bit_mux: the combinational index-to-bit selection, including the byte-order mapping, reusable by any future write-back loopback checker.

Test Plan:
1. Reset, then pts_en=1, mram_dq_in=16'hA55A, single read_en_n low pulse of 4 cycles -> word_out=16'hA55A exactly SETTLE_CYCLES+2 cycles after the strobe falls; word_valid=1; capture_cnt=1.
2. After capture of 16'h12C3, sweep index 0..15 one step per cycle -> ser_data_out sequence, 1 cycle delayed, is 1,1,0,0,0,0,1,1, then 0,0,0,1,0,0,1,0.
3. Burst: three strobes with dq=16'h0001, 16'h8000, 16'hFFFF -> word_out tracks each value; capture_cnt=3; ser_data_out is 0 while word_valid=0 before the first capture.
4. pts_en drops during SETTLE -> no capture; word_out unchanged; word_valid=0; ser_data_out=0 on the next edge.
5. FPGA_rst_n asserted in CAPTURE with dq=16'hBEEF -> all outputs are 0 immediately; after release, a strobe with dq=16'h0F0F captures 16'h0F0F and capture_cnt=1.
6. With MRAM_PTS_SAMPLE_VOTE_EN defined, dq=16'h00FF, 16'h0000, 16'h00FF on the three sample cycles -> word_out=16'h00FF.
